// File: rtl/batch_initiator_pkg.sv
// Shared state encoding and start/done token field offsets for batch_initiator.
package initiator_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_IDLE = 3'd1,
      START     = 3'd2,
      RUN       = 3'd3,
      DONE_OUT  = 3'd4
   } state_t;

   localparam int RUNS_LSB = 0;

   function automatic int mask_lsb(input int cnt_w);
      return RUNS_LSB + cnt_w;
   endfunction

   function automatic int timeout_bit(input int tdata_w);
      return tdata_w - 1;
   endfunction

endpackage

// File: rtl/kernel_hs_latch.sv
// Per-kernel ap_ctrl_hs ready/done latches and ap_start generation.
// A disabled kernel reports both latches as set so it never blocks a round.
module kernel_hs_latch (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   input  logic start_win,
   input  logic hs_win,
   input  logic ap_ready,
   input  logic ap_done,
   output logic ap_start,
   output logic ready_ok,
   output logic done_ok
);

   logic ready_q;
   logic done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else if (clr) begin
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         if (en && hs_win && ap_ready) ready_q <= 1'b1;
         if (en && hs_win && ap_done)  done_q  <= 1'b1;
      end
   end

   assign ap_start = en && start_win && !ready_q;
   assign ready_ok = !en || ready_q;
   assign done_ok  = !en || done_q;

endmodule

// File: rtl/batch_initiator.sv
// Multi-run, multi-kernel ap_ctrl_hs start/done controller driven by AXI-Stream tokens.
// Optional per-run watchdog enabled with `define BATCH_INITIATOR_TIMEOUT_EN.
module batch_initiator
   import initiator_pkg::*;
#(
   parameter int N_KERNELS          = 1,
   parameter int C_AXIS_TDATA_WIDTH = 32,
   parameter int CNT_W              = 16,
   parameter int TIMEOUT_CYCLES     = 1048576
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_start_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_start_axis_tstrb,
   input  logic                            s_start_axis_tvalid,
   output logic                            s_start_axis_tready,
   input  logic                            s_start_axis_tlast,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m_done_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_done_axis_tstrb,
   output logic                            m_done_axis_tvalid,
   input  logic                            m_done_axis_tready,
   output logic                            m_done_axis_tlast,
   output logic [N_KERNELS-1:0]            ap_start,
   input  logic [N_KERNELS-1:0]            ap_done,
   input  logic [N_KERNELS-1:0]            ap_idle,
   input  logic [N_KERNELS-1:0]            ap_ready
);

   localparam int MASK_LSB = mask_lsb(CNT_W);
   localparam int TO_BIT   = timeout_bit(C_AXIS_TDATA_WIDTH);

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     runs_in;
   logic [CNT_W-1:0]     runs_q;
   logic [CNT_W-1:0]     run_cnt;
   logic [CNT_W-1:0]     cnt_inc;
   logic [N_KERNELS-1:0] mask_in;
   logic [N_KERNELS-1:0] mask_q;
   logic [N_KERNELS-1:0] en;
   logic [N_KERNELS-1:0] ready_ok;
   logic [N_KERNELS-1:0] done_ok;
   logic                 accept;
   logic                 all_idle;
   logic                 all_ready;
   logic                 all_done;
   logic                 run_done;
   logic                 hs_win;
   logic                 start_win;
   logic                 timeout;
   logic                 to_fire;
   logic                 to_flag;
   logic                 latch_clr;
   logic                 unused_inputs;

   assign runs_in   = s_start_axis_tdata[RUNS_LSB +: CNT_W];
   assign mask_in   = s_start_axis_tdata[MASK_LSB +: N_KERNELS];
   assign en        = (mask_q == '0) ? '1 : mask_q;
   assign all_idle  = &(ap_idle | ~en);
   assign all_ready = &ready_ok;
   assign all_done  = &done_ok;
   assign cnt_inc   = run_cnt + 1'b1;
   assign accept    = s_start_axis_tready && s_start_axis_tvalid;
   assign hs_win    = (state == START) || (state == RUN);
   assign run_done  = (state == RUN) && all_done;
   // A run that completes in the same cycle the watchdog expires counts as completed.
   assign to_fire   = timeout && !run_done;
   assign start_win = (state == START) && !to_fire;
   assign latch_clr = accept || run_done || to_fire;

   assign unused_inputs = ^{s_start_axis_tstrb, s_start_axis_tlast, s_start_axis_tdata};

`ifdef BATCH_INITIATOR_TIMEOUT_EN
   logic [31:0] wd_cnt;

   // Restarts on every entry into START so the limit applies per run.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset)                                    wd_cnt <= '0;
      else if (state != START && state_next == START) wd_cnt <= '0;
      else if (hs_win)                               wd_cnt <= wd_cnt + 32'd1;
   end

   assign timeout = hs_win && (wd_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (accept) state_next = (runs_in == '0) ? DONE_OUT : WAIT_IDLE;
         WAIT_IDLE: if (all_idle) state_next = START;
         START: begin
            if (to_fire)        state_next = DONE_OUT;
            else if (all_ready) state_next = RUN;
         end
         RUN: begin
            if (run_done)     state_next = (cnt_inc == runs_q) ? DONE_OUT : START;
            else if (to_fire) state_next = DONE_OUT;
         end
         DONE_OUT:  if (m_done_axis_tready) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      s_start_axis_tready = (state == IDLE) && !areset;
      m_done_axis_tvalid  = (state == DONE_OUT);
      m_done_axis_tdata   = '0;
      if (state == DONE_OUT) begin
         m_done_axis_tdata[RUNS_LSB +: CNT_W] = run_cnt;
         m_done_axis_tdata[TO_BIT]            = to_flag;
      end
   end

   assign m_done_axis_tstrb = '1;
   assign m_done_axis_tlast = 1'b1;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         runs_q  <= '0;
         mask_q  <= '0;
         run_cnt <= '0;
         to_flag <= 1'b0;
      end else begin
         if (accept) begin
            runs_q  <= runs_in;
            mask_q  <= mask_in;
            run_cnt <= '0;
            to_flag <= 1'b0;
         end else begin
            if (run_done) run_cnt <= cnt_inc;
            if (to_fire)  to_flag <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < N_KERNELS; i++) begin : g_kernel
      kernel_hs_latch u_latch (
         .clk       (aclk),
         .rst       (areset),
         .en        (en[i]),
         .clr       (latch_clr),
         .start_win (start_win),
         .hs_win    (hs_win),
         .ap_ready  (ap_ready[i]),
         .ap_done   (ap_done[i]),
         .ap_start  (ap_start[i]),
         .ready_ok  (ready_ok[i]),
         .done_ok   (done_ok[i])
      );
   end

endmodule

// File: tb/tb_batch_initiator.sv
// Directed bench for batch_initiator with two behavioural ap_ctrl_hs kernels.
module tb_batch_initiator;

   localparam int NK = 2;
   localparam int W  = 32;
   localparam int CW = 16;

   logic          aclk = 1'b0;
   logic          areset;
   logic [W-1:0]  s_tdata;
   logic [W/8-1:0] s_tstrb;
   logic          s_tvalid;
   logic          s_tready;
   logic          s_tlast;
   logic [W-1:0]  m_tdata;
   logic [W/8-1:0] m_tstrb;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;
   logic [NK-1:0] ap_start;
   logic [NK-1:0] ap_done;
   logic [NK-1:0] ap_idle;
   logic [NK-1:0] ap_ready;

   batch_initiator #(
      .N_KERNELS(NK), .C_AXIS_TDATA_WIDTH(W), .CNT_W(CW), .TIMEOUT_CYCLES(64)
   ) dut (
      .aclk(aclk), .areset(areset),
      .s_start_axis_tdata(s_tdata), .s_start_axis_tstrb(s_tstrb),
      .s_start_axis_tvalid(s_tvalid), .s_start_axis_tready(s_tready),
      .s_start_axis_tlast(s_tlast),
      .m_done_axis_tdata(m_tdata), .m_done_axis_tstrb(m_tstrb),
      .m_done_axis_tvalid(m_tvalid), .m_done_axis_tready(m_tready),
      .m_done_axis_tlast(m_tlast),
      .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready)
   );

   always #5 aclk = ~aclk;

   // Kernel model knobs and state; inputs change on the falling edge only.
   int done_dly[NK];
   int hang_on[NK];
   bit dead[NK];
   bit stall[NK];
   int starts[NK];
   int cnt[NK];
   bit busy[NK];
   bit hung[NK];
   bit kreset = 1'b1;

   always @(negedge aclk) begin
      for (int k = 0; k < NK; k++) begin
         if (kreset) begin
            busy[k] = 0; hung[k] = 0; cnt[k] = 0; starts[k] = 0;
            ap_ready[k] = 1'b0; ap_done[k] = 1'b0; ap_idle[k] = !dead[k];
         end else begin
            ap_ready[k] = 1'b0;
            ap_done[k]  = 1'b0;
            if (ap_start[k]) starts[k]++;
            if (dead[k]) begin
               ap_idle[k] = 1'b0;
            end else if (!busy[k]) begin
               ap_idle[k] = 1'b1;
               if (ap_start[k] && !stall[k]) begin
                  ap_ready[k] = 1'b1;
                  ap_idle[k]  = 1'b0;
                  if (hang_on[k] != 0 && starts[k] == hang_on[k]) begin
                     busy[k] = 1; hung[k] = 1;
                  end else if (done_dly[k] == 0) begin
                     ap_done[k] = 1'b1;
                  end else begin
                     busy[k] = 1; cnt[k] = done_dly[k];
                  end
               end
            end else begin
               ap_idle[k] = 1'b0;
               if (!hung[k]) begin
                  cnt[k]--;
                  if (cnt[k] == 0) begin
                     ap_done[k] = 1'b1;
                     busy[k] = 0;
                  end
               end
            end
         end
      end
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic set_knobs(input int d0, input int d1, input bit dd0, input bit dd1);
      done_dly[0] = d0; done_dly[1] = d1;
      dead[0] = dd0; dead[1] = dd1;
      stall[0] = 0; stall[1] = 0;
      hang_on[0] = 0; hang_on[1] = 0;
   endtask

   task automatic clear_model();
      @(posedge aclk); #1 kreset = 1'b1;
      @(posedge aclk); #1 kreset = 1'b0;
   endtask

   task automatic send_token(input int runs, input int mask);
      @(negedge aclk);
      s_tdata = '0;
      s_tdata[CW-1:0] = runs[CW-1:0];
      s_tdata[CW +: NK] = mask[NK-1:0];
      s_tvalid = 1'b1;
      @(posedge aclk); #1;
      s_tvalid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge aclk);
         if (m_tvalid) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge aclk); areset = 1'b1;
      @(negedge aclk); areset = 1'b0;
   endtask

   typedef struct {
      int     runs;
      int     mask;
      int     d0;
      int     d1;
      bit     dead0;
      bit     dead1;
      int     exp_data;
      int     exp_s0;
      int     exp_s1;
   } vec_t;

   task automatic run_vec(input vec_t v, input string tag);
      bit ok;
      set_knobs(v.d0, v.d1, v.dead0, v.dead1);
      clear_model();
      send_token(v.runs, v.mask);
      wait_done(3000, ok);
      chk({tag, "_seen"}, 64'(ok), 64'd1);
      chk({tag, "_tdata"}, 64'(m_tdata), 64'(v.exp_data));
      chk({tag, "_tlast"}, 64'(m_tlast), 64'd1);
      chk({tag, "_tstrb"}, 64'(m_tstrb), 64'hF);
      chk({tag, "_starts0"}, 64'(starts[0]), 64'(v.exp_s0));
      chk({tag, "_starts1"}, 64'(starts[1]), 64'(v.exp_s1));
      @(negedge aclk);
      chk({tag, "_tready_after"}, 64'({s_tready, m_tvalid}), 64'b10);
      if (!ok) pulse_reset();
   endtask

   vec_t vecs[5];

   initial begin
      bit ok;
      bit stable;
      int seen;
      logic [W-1:0] held;

      areset = 1'b1; s_tdata = '0; s_tstrb = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      m_tready = 1'b1;
      set_knobs(1, 1, 0, 0);

      // {runs, mask, d0, d1, dead0, dead1, exp tdata, exp starts0, exp starts1}
      vecs[0] = '{1, 0, 2, 2, 0, 0, 1, 1, 1};
      vecs[1] = '{3, 0, 0, 4, 0, 0, 3, 3, 3};
      vecs[2] = '{2, 1, 1, 0, 0, 1, 2, 2, 0};
      vecs[3] = '{4, 2, 0, 3, 1, 0, 4, 0, 4};
      vecs[4] = '{5, 3, 3, 0, 0, 0, 5, 5, 5};

      repeat (2) @(negedge aclk);
      chk("rst_outputs", 64'({s_tready, m_tvalid, ap_start}), 64'd0);
      chk("rst_tdata", 64'(m_tdata), 64'd0);
      @(negedge aclk); areset = 1'b0;
      @(negedge aclk);
      chk("idle_tready", 64'(s_tready), 64'd1);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Token to ap_start latency and ap_ready-driven deassert.
      set_knobs(3, 3, 0, 0);
      clear_model();
      send_token(1, 0);
      @(negedge aclk);
      chk("lat_wait_idle", 64'(ap_start), 64'd0);
      @(negedge aclk);
      chk("lat_start_t2", 64'(ap_start), 64'd3);
      @(negedge aclk);
      chk("start_drop", 64'(ap_start), 64'd0);
      wait_done(200, ok);
      chk("lat_done", 64'(m_tdata), 64'd1);
      @(negedge aclk);

      // Zero runs: done token one cycle after accept, no kernel activity.
      set_knobs(1, 1, 0, 0);
      clear_model();
      send_token(0, 0);
      @(negedge aclk);
      chk("zero_tvalid", 64'({m_tvalid, ap_start}), 64'b100);
      chk("zero_tdata", 64'(m_tdata), 64'd0);
      @(negedge aclk);
      chk("zero_starts", 64'(starts[0] + starts[1]), 64'd0);

      // Backpressure holds the done token unchanged.
      set_knobs(1, 2, 0, 0);
      clear_model();
      m_tready = 1'b0;
      send_token(2, 0);
      wait_done(200, ok);
      held = m_tdata;
      stable = ok;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         if (!m_tvalid || m_tdata !== held) stable = 0;
      end
      chk("bp_stable", 64'(stable), 64'd1);
      chk("bp_tdata", 64'(held), 64'd2);
      m_tready = 1'b1;
      @(negedge aclk);
      chk("bp_release", 64'({s_tready, m_tvalid}), 64'b10);

      // Reset while a stalled kernel has ap_start high drops it asynchronously.
      set_knobs(1, 1, 0, 0);
      stall[0] = 1;
      clear_model();
      send_token(2, 0);
      repeat (4) @(negedge aclk);
      chk("stall_start_high", 64'(ap_start[0]), 64'd1);
      #2 areset = 1'b1;
      #1 chk("rst_async_start", 64'({ap_start, s_tready}), 64'd0);
      stall[0] = 0;
      clear_model();
      @(negedge aclk); areset = 1'b0;

      // Reset in RUN: no done token afterwards, then a clean recovery run.
      set_knobs(30, 30, 0, 0);
      clear_model();
      send_token(3, 0);
      repeat (8) @(negedge aclk);
      #2 areset = 1'b1;
      #1 chk("rst_run_start", 64'(ap_start), 64'd0);
      clear_model();
      @(negedge aclk); areset = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge aclk);
         if (m_tvalid) seen++;
      end
      chk("rst_no_token", 64'(seen), 64'd0);
      run_vec('{1, 0, 1, 1, 0, 0, 1, 1, 1}, "recover");

`ifdef BATCH_INITIATOR_TIMEOUT_EN
      set_knobs(2, 2, 0, 0);
      hang_on[0] = 2;
      clear_model();
      send_token(2, 0);
      wait_done(500, ok);
      chk("to_seen", 64'(ok), 64'd1);
      chk("to_tdata", 64'(m_tdata), 64'h8000_0001);
      @(negedge aclk);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/batch_initiator.md
# batch_initiator

Multi-run, multi-kernel start/done controller between an AXI-Stream command channel and N HLS kernels using the `ap_ctrl_hs` protocol. One start token carries a run count and a kernel enable mask. The block issues that many back-to-back `ap_start`/`ap_done` rounds to the enabled kernels, then returns one done token reporting the completed-run count. It supersedes the single-shot initiator in the kernel-control layer.

## Interface

Parameters:
- `N_KERNELS`, 1: number of controlled kernels.
- `C_AXIS_TDATA_WIDTH`, 32: start/done stream data width. Must satisfy `CNT_W + N_KERNELS <= C_AXIS_TDATA_WIDTH` and `CNT_W <= C_AXIS_TDATA_WIDTH-1`.
- `CNT_W`, 16: run-count field width.
- `TIMEOUT_CYCLES`, 1048576: per-run watchdog limit. Used only with the timeout feature.

Ports:
- Clock: one clock, `aclk`, shared by all ports.
- Reset: `areset` is asynchronous and active-high.
- `aclk`  in  1  clock for all ports.
- `areset`  in  1  asynchronous, active-high reset.
- `s_start_axis_tdata`  in  C_AXIS_TDATA_WIDTH  `[CNT_W-1:0]` = runs; `[CNT_W +: N_KERNELS]` = enable mask.
- `s_start_axis_tstrb`  in  C_AXIS_TDATA_WIDTH/8  ignored.
- `s_start_axis_tvalid`  in  1  start token valid.
- `s_start_axis_tready`  out  1  high only in IDLE.
- `s_start_axis_tlast`  in  1  ignored.
- `m_done_axis_tdata`  out  C_AXIS_TDATA_WIDTH  `[CNT_W-1:0]` = runs completed; bit `[W-1]` = timeout flag; all other bits 0.
- `m_done_axis_tstrb`  out  C_AXIS_TDATA_WIDTH/8  all ones.
- `m_done_axis_tvalid`  out  1  done token valid.
- `m_done_axis_tready`  in  1  sink ready.
- `m_done_axis_tlast`  out  1  constant 1.
- `ap_start`  out  N_KERNELS  per-kernel start.
- `ap_done`, `ap_idle`, `ap_ready`  in  N_KERNELS  per-kernel status.

## Operation

- **Reset values:** state IDLE. `ap_start`=0, `m_done_axis_tvalid`=0, `m_done_axis_tdata`=0, `s_start_axis_tready`=0 while `areset`=1. All latches and counters are cleared.
- **Enable mask:** the mask is captured on token accept. A mask of 0 means all kernels are enabled. A disabled kernel gets `ap_start`=0 and its idle/ready/done inputs are ignored; it is treated as latched.
- **IDLE:** `s_start_axis_tready`=1. On `tvalid && tready`, capture runs and mask, clear the run counter, and go to WAIT_IDLE. If runs==0, go instead to DONE_OUT with tdata=0.
- **WAIT_IDLE:** stay until every enabled `ap_idle` is 1, then go to START.
- **START:** `ap_start[i]` = enabled[i] && !ready_latch[i], driven combinationally from state and latch. `ap_ready[i]` sets ready_latch[i]. When all enabled ready latches are set, go to RUN.
- **Done latching:** `ap_done[i]` sets done_latch[i] during START and RUN. `ap_done` and `ap_ready` arriving in the same cycle are both latched.
- **RUN:** when all enabled done latches are set, increment the run counter and clear both latch sets. If counter+1 == runs, go to DONE_OUT; otherwise go to START. There is no second idle check.
- **DONE_OUT:** `m_done_axis_tvalid`=1 with tdata stable until `m_done_axis_tready`, then go to IDLE.
- **Out-of-window inputs:** `ap_done`/`ap_ready` in IDLE, WAIT_IDLE or DONE_OUT are ignored.
- **Counter width:** the run counter is CNT_W bits. runs = 2^CNT_W−1 completes without wrap.

## Timing

- **Token to start:** token accepted in cycle t → WAIT_IDLE at t+1 → if all enabled kernels are idle, START with `ap_start` high at t+2.
- **Start deassert:** `ap_ready[i]` seen in cycle r → `ap_start[i]` low at r+1.
- **End of run:** last enabled `ap_done` at cycle d → latch visible at d+1 → next START or DONE_OUT at d+2. Minimum gap between successive rounds is 2 cycles of `ap_start` low.
- **Zero-run token:** done token tvalid at t+1.
- **Done handshake:** `tvalid` holds through backpressure. Transfer in cycle k → `s_start_axis_tready` high at k+1.
- **Mid-operation reset:** asynchronous return to IDLE. `ap_start` drops immediately and no done token is emitted.

## Configuration

- **`BATCH_INITIATOR_TIMEOUT_EN` defined:** a cycle counter clears on every START entry and counts in START and RUN.
  - On reaching `TIMEOUT_CYCLES`: drop `ap_start`, go to DONE_OUT with tdata[W-1]=1 and tdata[CNT_W-1:0] = runs completed so far.
- **Undefined:** no watchdog; a hung kernel stalls the block indefinitely. tdata[W-1] is always 0.

## Structure

- **Package `initiator_pkg`:** state enum (IDLE, WAIT_IDLE, START, RUN, DONE_OUT) and tdata field offset constants (runs LSB, mask LSB, timeout bit).
- **Sub-module `kernel_hs_latch`:** one per kernel via generate. Holds the ready and done latches with clear/enable inputs and produces `ap_start[i]`.

## Test plan

- **Single run:** N_KERNELS=2, token runs=1, mask=0 → one `ap_start` pulse to both kernels; done token tdata=1, tlast=1.
- **Skewed finishes:** runs=3, kernels finish with different delays and ap_done/ap_ready coincident → exactly 3 start rounds per kernel; done tdata=3.
- **Masked kernel:** mask=0b01, kernel 1 never asserts idle/done → kernel 1 `ap_start` stays 0; completion driven by kernel 0 alone.
- **Zero runs:** runs=0 → no `ap_start`; done token tdata=0 at t+1.
- **Backpressure and reset:** hold `m_done_axis_tready`=0 for 10 cycles → tvalid and tdata stable throughout. Assert `areset` mid-RUN → `ap_start`=0 immediately and no done token.
- **Timeout (macro on):** TIMEOUT_CYCLES=64, runs=2, kernel hangs in run 2 → done tdata[W-1]=1, tdata[CNT_W-1:0]=1.
